// File: rtl/spi_cmd_sched_if.sv
// Memory-side beat bus of the SPI command sequencer: one request/acknowledge
// handshake per beat, read data valid in the acknowledge cycle.
interface spi_cmd_sched_if;
    logic        bus_req;
    logic        bus_we;
    logic [23:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    // Sequencer side: issues beats, receives acknowledges.
    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    // Memory side: answers beats.
    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/spi_cmd_sched.sv
// Command sequencer behind the 64-bit SPI peek shifter. Detects frame end on
// the raw slave select, decodes the latched command word, runs a burst of
// write/read/check beats on the req/ack bus and publishes a status image that
// the shifter loads at the start of the next frame.
module spi_cmd_sched #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_n,
    input  logic [63:0] cmd_word,
    output logic [63:0] status_word,
    output logic        busy,
    spi_cmd_sched_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE
    } state_e;

    localparam logic [3:0]  OP_WRITE = 4'd1;
    localparam logic [3:0]  OP_READ  = 4'd2;
    localparam logic [3:0]  OP_CHECK = 4'd3;
    // One bit wider than the counter so TIMEOUT = 65535 compares cleanly.
    localparam logic [16:0] TMO_LIM  = 17'(TIMEOUT);

    state_e      state_q,     state_d;
    logic [2:0]  sync_q,      sync_d;
    logic [3:0]  op_q,        op_d;
    logic [15:0] pattern_q,   pattern_d;
    logic [23:0] addr_q,      addr_d;
    logic [3:0]  beats_q,     beats_d;
    logic [15:0] tmo_cnt_q,   tmo_cnt_d;
    logic        req_q,       req_d;
    logic        we_q,        we_d;
    logic [23:0] baddr_q,     baddr_d;
    logic [15:0] wdata_q,     wdata_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        overrun_q,   overrun_d;
    logic        timeout_q,   timeout_d;
    logic [3:0]  last_op_q,   last_op_d;
    logic [7:0]  mism_q,      mism_d;
    logic [15:0] last_rd_q,   last_rd_d;
    logic [15:0] csum_q,      csum_d;
    logic [15:0] seq_q,       seq_d;
    logic [63:0] status_q,    status_d;

    logic        frame_end;
    logic        ack_seen;
    logic [3:0]  cmd_op;
    logic        cmd_unused;

    // Bits [2:1] are the two oldest synchronizer stages: 0 then 1 is a
    // rising edge of slave select, i.e. the end of a frame.
    assign frame_end  = (sync_q[2:1] == 2'b01);
    // An acknowledge only counts while a beat is actually outstanding.
    assign ack_seen   = bus.bus_ack && req_q;
    assign cmd_op     = cmd_word[63:60];
    assign cmd_unused = ^cmd_word[15:0];

    // Next-state, datapath and status computation.
    always_comb begin
        // NOTE: every target gets a default before the case so that no path
        // leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        sync_d    = {sync_q[1:0], sel_n};
        op_d      = op_q;
        pattern_d = pattern_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        tmo_cnt_d = tmo_cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        baddr_d   = baddr_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        last_op_d = last_op_q;
        mism_d    = mism_q;
        last_rd_d = last_rd_q;
        csum_d    = csum_q;
        seq_d     = seq_q;

        unique case (state_q)
            S_IDLE: begin
                if (frame_end) state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                seq_d     = seq_q + 16'd1;
                last_op_d = cmd_op;
                if (cmd_op == OP_WRITE || cmd_op == OP_READ || cmd_op == OP_CHECK) begin
                    op_d      = cmd_op;
                    beats_d   = cmd_word[59:56];
                    addr_d    = cmd_word[55:32];
                    pattern_d = cmd_word[31:16];
                    csum_d    = 16'd0;
                    mism_d    = 8'd0;
                    timeout_d = 1'b0;
                    overrun_d = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    // NOP (and reserved opcodes): clear the error flags only.
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end
            end

            S_ISSUE: begin
                req_d     = 1'b1;
                we_d      = (op_q == OP_WRITE);
                baddr_d   = addr_q;
                wdata_d   = pattern_q;
                tmo_cnt_d = 16'd0;
                state_d   = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (ack_seen) begin
                    req_d = 1'b0;
                    if (op_q != OP_WRITE) begin
                        csum_d    = csum_q ^ bus.bus_rdata;
                        last_rd_d = bus.bus_rdata;
                    end
                    if (op_q == OP_CHECK && bus.bus_rdata != pattern_q && mism_q != 8'hFF) begin
                        mism_d = mism_q + 8'd1;
                    end
                    addr_d = addr_q + 24'd1;
                    if (beats_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        beats_d = beats_q - 4'd1;
                        state_d = S_ISSUE;
                    end
                end else if ({1'b0, tmo_cnt_q} + 17'd1 == TMO_LIM) begin
                    // Abort: remaining beats are abandoned.
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // A frame that ends while a command is in flight is dropped; this
        // takes priority over the flag clear performed in CAPTURE.
        if (frame_end && state_q != S_IDLE) overrun_d = 1'b1;

        // Built from next-state values so the status word reflects an ack
        // on the very next cycle.
        status_d = {busy_d, overrun_d, timeout_d, done_d, last_op_d,
                    mism_d, last_rd_d, csum_d, seq_d};
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sync_q    <= 3'b111;
            op_q      <= 4'd0;
            pattern_q <= 16'd0;
            addr_q    <= 24'd0;
            beats_q   <= 4'd0;
            tmo_cnt_q <= 16'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            baddr_q   <= 24'd0;
            wdata_q   <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            last_op_q <= 4'd0;
            mism_q    <= 8'd0;
            last_rd_q <= 16'd0;
            csum_q    <= 16'd0;
            seq_q     <= 16'd0;
            status_q  <= 64'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its inputs regardless of statement order.
            state_q   <= state_d;
            sync_q    <= sync_d;
            op_q      <= op_d;
            pattern_q <= pattern_d;
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            tmo_cnt_q <= tmo_cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            last_op_q <= last_op_d;
            mism_q    <= mism_d;
            last_rd_q <= last_rd_d;
            csum_q    <= csum_d;
            seq_q     <= seq_d;
            status_q  <= status_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_wdata = wdata_q;
    assign busy          = busy_q;
    assign status_word   = status_q;

endmodule
